// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the pipeline-side request ports and the external
// SRAM bus of sram_arbiter.
//   Pipeline side : stall, flush, if_* (fetch), mem_* (data access),
//                   stallreq_from_if/mem, bus_err
//   SRAM side     : sram_ce/we/sel/addr/wdata (registered), sram_rdata, sram_ack
// Modports:
//   slave  - the arbiter itself (serves the two pipeline requesters)
//   master - the environment: pipeline stages plus the SRAM model
interface sram_arbiter_if;
    logic [5:0]  stall;
    logic        flush;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stallreq_from_if;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;

    logic        bus_err;

    logic        sram_ce;
    logic        sram_we;
    logic [3:0]  sram_sel;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ack;

    modport slave (
        input  stall, flush,
        input  if_req, if_addr,
        output if_rdata, stallreq_from_if,
        input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata, stallreq_from_mem,
        output bus_err,
        output sram_ce, sram_we, sram_sel, sram_addr, sram_wdata,
        input  sram_rdata, sram_ack
    );

    modport master (
        output stall, flush,
        output if_req, if_addr,
        input  if_rdata, stallreq_from_if,
        output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata, stallreq_from_mem,
        input  bus_err,
        input  sram_ce, sram_we, sram_sel, sram_addr, sram_wdata,
        output sram_rdata, sram_ack
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM port between instruction fetch (IF)
// and the MEM stage. One requester is granted at a time (MEM first, it is the
// older instruction); the bus transaction is registered and guarded by a
// timeout watchdog. Results are held in rdata registers until the pipeline
// consumes them.
// Ports:
//   clk       - clock, all state on the rising edge
//   rst       - synchronous active-high reset
//   bus       - sram_arbiter_if.slave (pipeline requests + SRAM bus)
//   dbg_state - current FSM state (0 IDLE, 1 BUS_IF, 2 BUS_MEM)
//
// Handshake: a requester holds x_req high until its result is consumed.
// x_done rises the cycle after completion and stays high until a cycle in
// which that stage is not stalled; stallreq_from_x = x_req & ~x_done. On the
// SRAM side sram_ce stays high, with address/data constant, until the cycle
// sram_ack = 1 (or the watchdog expires); sram_ce then drops for at least
// one cycle before the next transaction.
module sram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    sram_arbiter_if.slave       bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic        ce_q, ce_nxt;
    logic        we_q, we_nxt;
    logic [3:0]  sel_q, sel_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [31:0] if_rdata_q, if_rdata_nxt;
    logic [31:0] mem_rdata_q, mem_rdata_nxt;
    logic        bus_err_q, bus_err_nxt;
    logic        if_done, if_done_nxt;
    logic        mem_done, mem_done_nxt;
    logic        drop, drop_nxt;
    logic [7:0]  cnt, cnt_nxt;

    logic        if_elig, mem_elig, timeout, discard;

    // Stall bits of stages this block does not serve.
    logic        unused_stall;
    assign unused_stall = ^{bus.stall[5], bus.stall[3:2], bus.stall[0]};

    assign if_elig  = bus.if_req  & ~if_done;
    assign mem_elig = bus.mem_req & ~mem_done;
    assign timeout  = (cnt == TIMEOUT_CNT);
    // A flush in the completion cycle discards the result just like an
    // earlier flush recorded in drop.
    assign discard  = drop | bus.flush;

    always_comb begin
        state_nxt     = state;
        ce_nxt        = ce_q;
        we_nxt        = we_q;
        sel_nxt       = sel_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        if_rdata_nxt  = if_rdata_q;
        mem_rdata_nxt = mem_rdata_q;
        bus_err_nxt   = 1'b0;
        cnt_nxt       = cnt;
        drop_nxt      = drop;
        // Done flags drop once the stage advances, or on flush; a
        // completion below overrides this (new result not yet consumed).
        if_done_nxt   = if_done  & bus.stall[1] & ~bus.flush;
        mem_done_nxt  = mem_done & bus.stall[4] & ~bus.flush;

        case (state)
            IDLE: begin
                if (mem_elig) begin
                    state_nxt = BUS_MEM;
                    ce_nxt    = 1'b1;
                    we_nxt    = bus.mem_we;
                    sel_nxt   = bus.mem_sel;
                    addr_nxt  = bus.mem_addr;
                    wdata_nxt = bus.mem_wdata;
                    cnt_nxt   = 8'd0;
                    // A request granted in a flush cycle belongs to a
                    // squashed instruction.
                    drop_nxt  = bus.flush;
                end else if (if_elig) begin
                    state_nxt = BUS_IF;
                    ce_nxt    = 1'b1;
                    we_nxt    = 1'b0;
                    sel_nxt   = 4'b1111;
                    addr_nxt  = bus.if_addr;
                    wdata_nxt = 32'd0;
                    cnt_nxt   = 8'd0;
                    drop_nxt  = bus.flush;
                end
            end
            BUS_IF, BUS_MEM: begin
                if (bus.sram_ack || timeout) begin
                    state_nxt   = IDLE;
                    ce_nxt      = 1'b0;
                    we_nxt      = 1'b0;
                    sel_nxt     = 4'b0000;
                    drop_nxt    = 1'b0;
                    bus_err_nxt = ~bus.sram_ack;
                    if (state == BUS_IF) begin
                        if_rdata_nxt = bus.sram_ack ? bus.sram_rdata : 32'd0;
                        if (!discard) begin
                            if_done_nxt = 1'b1;
                        end
                    end else begin
                        if (!we_q) begin
                            mem_rdata_nxt = bus.sram_ack ? bus.sram_rdata : 32'd0;
                        end
                        if (!discard) begin
                            mem_done_nxt = 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    if (bus.flush) begin
                        drop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ce_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ce_q        <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'b0000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            bus_err_q   <= 1'b0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
            drop        <= 1'b0;
            cnt         <= 8'd0;
        end else begin
            state       <= state_nxt;
            ce_q        <= ce_nxt;
            we_q        <= we_nxt;
            sel_q       <= sel_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            if_rdata_q  <= if_rdata_nxt;
            mem_rdata_q <= mem_rdata_nxt;
            bus_err_q   <= bus_err_nxt;
            if_done     <= if_done_nxt;
            mem_done    <= mem_done_nxt;
            drop        <= drop_nxt;
            cnt         <= cnt_nxt;
        end
    end

    assign bus.sram_ce    = ce_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_sel   = sel_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.bus_err    = bus_err_q;

    // Gated by rst so every output reads 0 while reset is held.
    assign bus.stallreq_from_if  = bus.if_req  & ~if_done  & ~rst;
    assign bus.stallreq_from_mem = bus.mem_req & ~mem_done & ~rst;

    assign dbg_state = state;

endmodule
